dram_frame_scheduler: RTL and testbench

Sequences frame writes through the AXI DRAM writer: programs the writer with one frame-sized write per buffer of an NBUF-deep ring of DRAM frame buffers, snoops AXI B responses to detect frame completion, and withholds new frames while every buffer is held by the downstream consumer. Sits between host control registers and the writer's CONFIG port; write data flows directly to the writer, not through this block.

---
 rtl/dram_sched_pkg.sv | 13 +
 rtl/dram_buf_ring.sv | 60 ++++++
 rtl/dram_frame_scheduler.sv | 106 ++++++++++
 tb/tb_dram_frame_scheduler.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/dram_sched_pkg.sv
// dram_sched_pkg: shared types and constants for the DRAM frame scheduler.
//   state_t     - scheduler FSM states
//   BURST_BYTES - bytes moved by one AXI burst (16 beats x 8 B)
//   BURST_SHIFT - log2(BURST_BYTES), converts bytes to bursts
//   NB_W        - width of a frame length expressed in bursts
//   IDX_W       - width of a ring buffer index
package dram_sched_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_B, STALL} state_t;
    localparam int BURST_BYTES = 128;
    localparam int BURST_SHIFT = $clog2(BURST_BYTES);
    localparam int NB_W = 32 - BURST_SHIFT;
    localparam int IDX_W = 4;
endpackage

// File: rtl/dram_buf_ring.sv
// dram_buf_ring: bookkeeping for the ring of DRAM frame buffers.
//   clk, rst_n     - clock, synchronous active-low reset
//   load           - capture base/stride, restart ring at buffer 0
//   base, stride   - address of buffer 0 and step between buffers
//   adv            - a frame completed: count it as held, move to next buffer
//   rel            - consumer frees the oldest held buffer
//   wr_idx, addr   - buffer the next frame is written into
//   room           - after this cycle's updates, fewer than NBUF buffers held
module dram_buf_ring
    import dram_sched_pkg::*;
#(
    parameter int NBUF = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [31:0]      base,
    input  logic [31:0]      stride,
    input  logic             adv,
    input  logic             rel,
    output logic [IDX_W-1:0] wr_idx,
    output logic [31:0]      addr,
    output logic             room
);
    localparam logic [4:0] FULL = 5'(NBUF);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NBUF - 1);

    logic [4:0]  held, held_next;
    logic [31:0] base_q, stride_q;
    logic        dec, wrap;

    // A release with nothing held is meaningless and is dropped.
    always_comb begin
        dec = rel && held != 5'd0;
        wrap = wr_idx == LAST;
        held_next = held + {4'd0, adv} - {4'd0, dec};
        room = held_next < FULL;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            held <= '0;
            wr_idx <= '0;
            addr <= '0;
            base_q <= '0;
            stride_q <= '0;
        end else begin
            held <= held_next;
            if (load) begin
                base_q <= base;
                stride_q <= stride;
                wr_idx <= '0;
                addr <= base;
            end else if (adv) begin
                wr_idx <= wrap ? '0 : wr_idx + 1'b1;
                addr <= wrap ? base_q : addr + stride_q;
            end
        end
    end
endmodule

// File: rtl/dram_frame_scheduler.sv
// dram_frame_scheduler: programs the AXI DRAM writer with one frame per ring buffer.
//   ACLK, ARESETN                      - clock, synchronous active-low reset
//   START, STOP                        - host run control (levels)
//   BASE_ADDR, FRAME_BYTES, FRAME_STRIDE - ring geometry, captured at START
//   CFG_VALID/READY, CFG_START_ADDR, CFG_NBYTES - writer CONFIG handshake
//   BVALID, BRESP                      - snooped AXI write responses
//   FRAME_DONE, FRAME_IDX              - completed-frame pulse and its buffer
//   RELEASE                            - consumer frees oldest held buffer
//   BUSY, ERROR                        - not idle; sticky error
module dram_frame_scheduler
    import dram_sched_pkg::*;
#(
    parameter int NBUF = 4
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic             START,
    input  logic             STOP,
    input  logic [31:0]      BASE_ADDR,
    input  logic [31:0]      FRAME_BYTES,
    input  logic [31:0]      FRAME_STRIDE,
    output logic             CFG_VALID,
    input  logic             CFG_READY,
    output logic [31:0]      CFG_START_ADDR,
    output logic [31:0]      CFG_NBYTES,
    input  logic             BVALID,
    input  logic [1:0]       BRESP,
    output logic             FRAME_DONE,
    output logic [IDX_W-1:0] FRAME_IDX,
    input  logic             RELEASE,
    output logic             BUSY,
    output logic             ERROR
);
    state_t           state, state_next;
    logic [NB_W-1:0]  nbursts, bursts_left;
    logic             start, hs, bv, last, room;
    logic [IDX_W-1:0] wr_idx;
    logic [31:0]      addr;
    logic             unused_low;

    // Sub-burst byte counts are truncated away.
    assign unused_low = ^FRAME_BYTES[BURST_SHIFT-1:0];
    assign CFG_NBYTES = {nbursts, {BURST_SHIFT{1'b0}}};

    dram_buf_ring #(.NBUF(NBUF)) ring (
        .clk    (ACLK),
        .rst_n  (ARESETN),
        .load   (start),
        .base   (BASE_ADDR),
        .stride (FRAME_STRIDE),
        .adv    (last),
        .rel    (RELEASE),
        .wr_idx (wr_idx),
        .addr   (addr),
        .room   (room)
    );

    // room reflects this cycle's done/release, so decisions see post-update held.
    always_comb begin
        state_next = state;
        start = state == IDLE && START;
        hs = state == ISSUE && CFG_VALID && CFG_READY;
        bv = state == WAIT_B && BVALID;
        last = bv && bursts_left == NB_W'(1);
        case (state)
            IDLE:    if (start && FRAME_BYTES[31:BURST_SHIFT] != '0) state_next = room ? ISSUE : STALL;
            ISSUE:   if (hs) state_next = WAIT_B;
            WAIT_B:  if (last) state_next = STOP ? IDLE : (room ? ISSUE : STALL);
            STALL:   state_next = STOP ? IDLE : (room ? ISSUE : STALL);
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) state <= IDLE;
        else state <= state_next;
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            CFG_VALID <= 1'b0;
            CFG_START_ADDR <= '0;
            nbursts <= '0;
            bursts_left <= '0;
            FRAME_DONE <= 1'b0;
            FRAME_IDX <= '0;
            BUSY <= 1'b0;
            ERROR <= 1'b0;
        end else begin
            // Valid rises one cycle after entering ISSUE, address latched with it.
            CFG_VALID <= state == ISSUE && !hs;
            if (state == ISSUE && !CFG_VALID) CFG_START_ADDR <= addr;
            FRAME_DONE <= last;
            if (last) FRAME_IDX <= wr_idx;
            BUSY <= state_next != IDLE;
            if (start) begin
                nbursts <= FRAME_BYTES[31:BURST_SHIFT];
                ERROR <= FRAME_BYTES[31:BURST_SHIFT] == '0;
            end else if (bv && BRESP != 2'b00) begin
                ERROR <= 1'b1;
            end
            if (hs) bursts_left <= nbursts;
            else if (bv) bursts_left <= bursts_left - 1'b1;
        end
    end
endmodule

// File: tb/tb_dram_frame_scheduler.sv
// tb_dram_frame_scheduler: directed self-checking bench for dram_frame_scheduler.
module tb_dram_frame_scheduler;
    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        START = 1'b0, STOP = 1'b0;
    logic [31:0] BASE_ADDR = 32'h1000_0000;
    logic [31:0] FRAME_BYTES = 32'd512;
    logic [31:0] FRAME_STRIDE = 32'h1000;
    logic        CFG_VALID, CFG_READY = 1'b0;
    logic [31:0] CFG_START_ADDR, CFG_NBYTES;
    logic        BVALID = 1'b0;
    logic [1:0]  BRESP = 2'b00;
    logic        FRAME_DONE;
    logic [3:0]  FRAME_IDX;
    logic        RELEASE = 1'b0;
    logic        BUSY, ERROR;

    int tests = 0, fails = 0;

    dram_frame_scheduler #(.NBUF(4)) dut (
        .ACLK           (ACLK),
        .ARESETN        (ARESETN),
        .START          (START),
        .STOP           (STOP),
        .BASE_ADDR      (BASE_ADDR),
        .FRAME_BYTES    (FRAME_BYTES),
        .FRAME_STRIDE   (FRAME_STRIDE),
        .CFG_VALID      (CFG_VALID),
        .CFG_READY      (CFG_READY),
        .CFG_START_ADDR (CFG_START_ADDR),
        .CFG_NBYTES     (CFG_NBYTES),
        .BVALID         (BVALID),
        .BRESP          (BRESP),
        .FRAME_DONE     (FRAME_DONE),
        .FRAME_IDX      (FRAME_IDX),
        .RELEASE        (RELEASE),
        .BUSY           (BUSY),
        .ERROR          (ERROR)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge ACLK);
    endtask

    task automatic do_reset();
        ARESETN = 1'b0;
        {START, STOP, CFG_READY, BVALID, RELEASE} = '0;
        BRESP = 2'b00;
        FRAME_BYTES = 32'd512;
        tick();
        tick();
        ARESETN = 1'b1;
    endtask

    // START and RELEASE are one-cycle pulses: cleared after every tick here.
    task automatic wait_cfg(input int exp_n);
        int n = 0;
        while (!CFG_VALID && n < 20) begin
            tick();
            START = 1'b0;
            RELEASE = 1'b0;
            n++;
        end
        check("cfg_latency", n, exp_n);
    endtask

    // rel: 0 none, 1 pulse after FRAME_DONE, 2 coincident with last BVALID.
    task automatic frame(input logic [31:0] ea, input int ei, input int bad, input int rel, input logic stp);
        check("cfg_addr", CFG_START_ADDR, ea);
        check("cfg_nbytes", CFG_NBYTES, 32'd512);
        CFG_READY = 1'b1;
        tick();
        CFG_READY = 1'b0;
        check("cfg_drop", CFG_VALID, 1'b0);
        STOP = stp;
        for (int i = 0; i < 4; i++) begin
            BVALID = 1'b1;
            BRESP = (i == bad) ? 2'b10 : 2'b00;
            RELEASE = rel == 2 && i == 3;
            tick();
            if (i == 2) check("done_early", FRAME_DONE, 1'b0);
        end
        {BVALID, RELEASE, STOP} = '0;
        BRESP = 2'b00;
        check("frame_done", FRAME_DONE, 1'b1);
        check("frame_idx", FRAME_IDX, ei);
        check("busy_after_done", BUSY, !stp);
        RELEASE = rel == 1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset values
        do_reset();
        check("rst_cfg_valid", CFG_VALID, 0);
        check("rst_cfg_addr", CFG_START_ADDR, 0);
        check("rst_cfg_nbytes", CFG_NBYTES, 0);
        check("rst_done", FRAME_DONE, 0);
        check("rst_idx", FRAME_IDX, 0);
        check("rst_busy", BUSY, 0);
        check("rst_error", ERROR, 0);

        // Ring walk with release after each frame, wraps to buffer 0
        START = 1'b1;
        wait_cfg(2);
        for (int k = 0; k < 5; k++) begin
            frame(32'h1000_0000 + 32'h1000 * (k % 4), k % 4, 4, 1, 1'b0);
            wait_cfg(1);
        end

        // No release: four frames then stall, one release resumes
        do_reset();
        START = 1'b1;
        wait_cfg(2);
        for (int k = 0; k < 4; k++) begin
            frame(32'h1000_0000 + 32'h1000 * k, k, 4, 0, 1'b0);
            if (k < 3) wait_cfg(1);
        end
        for (int i = 0; i < 5; i++) tick();
        check("stall_valid", CFG_VALID, 0);
        check("stall_busy", BUSY, 1);
        RELEASE = 1'b1;
        wait_cfg(2);
        check("resume_addr", CFG_START_ADDR, 32'h1000_0000);

        // Bad response on second burst, frame still completes, START clears error
        do_reset();
        START = 1'b1;
        wait_cfg(2);
        frame(32'h1000_0000, 0, 1, 0, 1'b1);
        check("err_set", ERROR, 1);
        tick();
        check("err_sticky", ERROR, 1);
        check("err_idle", BUSY, 0);
        START = 1'b1;
        tick();
        START = 1'b0;
        check("err_cleared", ERROR, 0);

        // Sub-burst frame size rejected
        do_reset();
        FRAME_BYTES = 32'd100;
        START = 1'b1;
        tick();
        START = 1'b0;
        check("small_error", ERROR, 1);
        check("small_busy", BUSY, 0);
        for (int i = 0; i < 3; i++) tick();
        check("small_no_cfg", CFG_VALID, 0);

        // Release coincident with done at held=3, then STOP during WAIT_B
        do_reset();
        START = 1'b1;
        wait_cfg(2);
        for (int k = 0; k < 3; k++) begin
            frame(32'h1000_0000 + 32'h1000 * k, k, 4, 0, 1'b0);
            wait_cfg(1);
        end
        frame(32'h1000_3000, 3, 4, 2, 1'b0);
        wait_cfg(1);
        frame(32'h1000_0000, 0, 4, 0, 1'b1);
        tick();
        check("stop_busy", BUSY, 0);
        check("stop_no_cfg", CFG_VALID, 0);

        // Reset mid WAIT_B abandons the frame
        do_reset();
        START = 1'b1;
        wait_cfg(2);
        CFG_READY = 1'b1;
        tick();
        CFG_READY = 1'b0;
        BVALID = 1'b1;
        tick();
        tick();
        ARESETN = 1'b0;
        tick();
        check("mid_rst_valid", CFG_VALID, 0);
        check("mid_rst_addr", CFG_START_ADDR, 0);
        check("mid_rst_nbytes", CFG_NBYTES, 0);
        check("mid_rst_done", FRAME_DONE, 0);
        check("mid_rst_busy", BUSY, 0);
        check("mid_rst_error", ERROR, 0);
        ARESETN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_no_done", FRAME_DONE, 0);
        end
        BVALID = 1'b0;
        check("post_rst_busy", BUSY, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
